// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, issues word fetches, queues responses
// for ID and flushes stale in-flight responses on redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned MAX_OUTST  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        iport_req,
    output logic [31:0] iport_addr,
    input  logic        iport_gnt,
    input  logic        iport_rvalid,
    input  logic [31:0] iport_rdata,
    input  logic        iport_err,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
    output logic        id_fault
);

    localparam int unsigned OW = $clog2(MAX_OUTST + 1);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {BOOT, RUN, DRAIN, HALT} state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } entry_t;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [OW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    entry_t        mem_q [FIFO_DEPTH];

    logic          push;
    entry_t        push_e;
    logic [PW-1:0] wr_idx;
    logic          pop;
    logic          hs;
    logic          misalign;
    logic [31:0]   occ;
    entry_t        head;

    assign head      = mem_q[rd_q];
    assign id_valid  = (count_q != '0);
    assign pop       = id_valid && id_ready;
    assign misalign  = (redirect_pc[1:0] != 2'b00);
    assign iport_addr = pc_q;

    assign id_instruction = id_valid ? head.instr : NOP;
    assign id_pc          = id_valid ? head.pc : pc_q;
    assign id_fault       = id_valid && head.fault;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        outst_d   = outst_q;
        discard_d = discard_q;
        count_d   = count_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        wr_idx    = wr_q;
        push      = 1'b0;
        push_e    = '0;
        iport_req = 1'b0;
        // Credit counts the slot freed by this cycle's pop for 1 IPC.
        occ = 32'(count_q) + 32'(outst_q) - 32'(pop);

        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: iport_req = (occ < FIFO_DEPTH)
                          && (32'(outst_q) < MAX_OUTST)
                          && !redirect;
            DRAIN, HALT: ;
        endcase

        hs = iport_req && iport_gnt;
        if (hs) begin
            outst_d = outst_q + OW'(1);
            pc_d    = pc_q + 32'd4;
        end

        if (iport_rvalid) begin
            outst_d = outst_d - OW'(1);
            if (discard_q != '0) begin
                discard_d = discard_q - OW'(1);
            end else begin
                push         = 1'b1;
                push_e.pc    = pc_q - (32'(outst_q) << 2);
                push_e.instr = iport_err ? NOP : iport_rdata;
                push_e.fault = iport_err;
            end
        end

        if (state_q == DRAIN && discard_d == '0) begin
            state_d = RUN;
        end

        if (pop) begin
            rd_d = rd_q + PW'(1);
        end
        if (push) begin
            wr_d = wr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);

        if (redirect) begin
            push      = 1'b0;
            push_e    = '0;
            rd_d      = '0;
            wr_d      = '0;
            wr_idx    = '0;
            count_d   = '0;
            pc_d      = redirect_pc;
            discard_d = outst_d;
            if (misalign) begin
                push         = 1'b1;
                push_e.pc    = redirect_pc;
                push_e.instr = NOP;
                push_e.fault = 1'b1;
                wr_d         = PW'(1);
                count_d      = CW'(1);
                state_d      = HALT;
            end else begin
                state_d = (discard_d != '0) ? DRAIN : RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            pc_q      <= RESET_ADDR;
            outst_q   <= '0;
            discard_q <= '0;
            count_q   <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            count_q   <= count_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            if (push) begin
                mem_q[wr_idx] <= push_e;
            end
        end
    end

    // The issue credit must make a push into a full queue impossible.
    always_ff @(posedge clk) begin
        if (rst_n && !redirect) begin
            assert (!(push && !pop && count_q == CW'(FIFO_DEPTH)));
        end
    end

endmodule
